// File: rtl/gray_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// gray_sweep_ctrl
//   Sequencer and self-checker for a binary-to-Gray converter. On start it
//   walks binary_out through 0 .. 2^WIDTH-1, holding each code STEP_CYCLES
//   clocks. On the last hold cycle it samples gray_in and checks the value,
//   the single-bit change from the previous code, and (on the last code) the
//   single-bit wrap back to the first code. Errors are sticky per sweep.
//
// Ports
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   start       in   sweep request, honoured in IDLE and DONE
//   pause       in   freezes hold counter and sweep while high
//   gray_in     in   [WIDTH] converter output (combinational)
//   binary_out  out  [WIDTH] code driven into the converter
//   code_valid  out  one-cycle pulse after each sample edge
//   busy        out  sweep running
//   done        out  sweep finished, until next accepted start
//   err         out  sticky: any check failed this sweep
//   err_kind    out  [2] sticky: bit0 value mismatch, bit1 adjacency/wrap
//   err_code    out  [WIDTH] binary_out at the first failing sample
// ---------------------------------------------------------------------------
module gray_sweep_ctrl #(
    parameter int WIDTH       = 4,
    parameter int STEP_CYCLES = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             pause,
    input  logic [WIDTH-1:0] gray_in,
    output logic [WIDTH-1:0] binary_out,
    output logic             code_valid,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_kind,
    output logic [WIDTH-1:0] err_code
);

    localparam int               CNT_W     = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(STEP_CYCLES - 1);
    localparam logic [WIDTH-1:0] LAST_CODE = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             code_valid_q, code_valid_d;
    logic             err_q, err_d;
    logic [1:0]       err_kind_q, err_kind_d;
    logic [WIDTH-1:0] err_code_q, err_code_d;
    logic [WIDTH-1:0] prev_gray_q, prev_gray_d;
    logic [WIDTH-1:0] first_gray_q, first_gray_d;

    // Failures detected on the current sample edge.
    logic [1:0]       fail;

    // Exactly one bit set: consecutive Gray codes differ in one position.
    function automatic logic one_bit(input logic [WIDTH-1:0] v);
        return $countones(v) == 1;
    endfunction

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned; otherwise a latch would be inferred.
        state_d      = state_q;
        bin_d        = bin_q;
        cnt_d        = cnt_q;
        code_valid_d = 1'b0;
        err_d        = err_q;
        err_kind_d   = err_kind_q;
        err_code_d   = err_code_q;
        prev_gray_d  = prev_gray_q;
        first_gray_d = first_gray_q;
        fail         = 2'b00;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_RUN;
                    bin_d      = '0;
                    cnt_d      = '0;
                    err_d      = 1'b0;
                    err_kind_d = 2'b00;
                    err_code_d = '0;
                end
            end

            S_RUN: begin
                if (!pause) begin
                    if (cnt_q != CNT_LAST) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        // Sample edge for the current code.
                        code_valid_d = 1'b1;
                        if (gray_in != (bin_q ^ (bin_q >> 1))) fail[0] = 1'b1;

                        if (bin_q == '0) first_gray_d = gray_in;
                        else if (!one_bit(prev_gray_q ^ gray_in)) fail[1] = 1'b1;
                        prev_gray_d = gray_in;

                        if (bin_q != LAST_CODE) begin
                            bin_d = bin_q + WIDTH'(1);
                            cnt_d = '0;
                        end else begin
                            if (!one_bit(gray_in ^ first_gray_q)) fail[1] = 1'b1;
                            state_d = S_DONE;
                        end

                        // err_code latches only the first failing code.
                        if (err_kind_q == 2'b00 && fail != 2'b00) err_code_d = bin_q;
                        err_kind_d = err_kind_q | fail;
                        err_d      = |(err_kind_q | fail);
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop updates from
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            bin_q        <= '0;
            cnt_q        <= '0;
            code_valid_q <= 1'b0;
            err_q        <= 1'b0;
            err_kind_q   <= 2'b00;
            err_code_q   <= '0;
            prev_gray_q  <= '0;
            first_gray_q <= '0;
        end else begin
            state_q      <= state_d;
            bin_q        <= bin_d;
            cnt_q        <= cnt_d;
            code_valid_q <= code_valid_d;
            err_q        <= err_d;
            err_kind_q   <= err_kind_d;
            err_code_q   <= err_code_d;
            prev_gray_q  <= prev_gray_d;
            first_gray_q <= first_gray_d;
        end
    end

    assign binary_out = bin_q;
    assign code_valid = code_valid_q;
    assign busy       = (state_q == S_RUN);
    assign done       = (state_q == S_DONE);
    assign err        = err_q;
    assign err_kind   = err_kind_q;
    assign err_code   = err_code_q;

endmodule

// File: tb/tb_gray_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_gray_sweep_ctrl
//   Directed bench for gray_sweep_ctrl. Two instances: STEP_CYCLES=10 and
//   STEP_CYCLES=1, each fed by its own converter model (the STEP=10 one can
//   be forced to emit 0101 for input 0101). A per-cycle reference tracks the
//   expected binary_out and code_valid from the count of unpaused edges.
// ---------------------------------------------------------------------------
module tb_gray_sweep_ctrl;

    localparam int W = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic pause = 1'b0;
    logic sel   = 1'b0;  // 0: STEP=10 instance, 1: STEP=1 instance
    logic fault = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    logic [W-1:0] bin10, bin1, gray10, gray1, ec10, ec1;
    logic         cv10, cv1, busy10, busy1, done10, done1, err10, err1;
    logic [1:0]   ek10, ek1;
    logic         start10, start1;

    assign start10 = start & ~sel;
    assign start1  = start & sel;
    assign gray10  = (fault && bin10 == 4'd5) ? 4'b0101 : (bin10 ^ (bin10 >> 1));
    assign gray1   = bin1 ^ (bin1 >> 1);

    gray_sweep_ctrl #(.WIDTH(W), .STEP_CYCLES(10)) dut10 (
        .clk(clk), .rst_n(rst_n), .start(start10), .pause(pause), .gray_in(gray10),
        .binary_out(bin10), .code_valid(cv10), .busy(busy10), .done(done10),
        .err(err10), .err_kind(ek10), .err_code(ec10)
    );

    gray_sweep_ctrl #(.WIDTH(W), .STEP_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .pause(pause), .gray_in(gray1),
        .binary_out(bin1), .code_valid(cv1), .busy(busy1), .done(done1),
        .err(err1), .err_kind(ek1), .err_code(ec1)
    );

    // Observed outputs of the selected instance.
    logic [W-1:0] o_bin, o_ec;
    logic         o_cv, o_busy, o_done, o_err;
    logic [1:0]   o_ek;
    assign o_bin  = sel ? bin1  : bin10;
    assign o_ec   = sel ? ec1   : ec10;
    assign o_cv   = sel ? cv1   : cv10;
    assign o_busy = sel ? busy1 : busy10;
    assign o_done = sel ? done1 : done10;
    assign o_err  = sel ? err1  : err10;
    assign o_ek   = sel ? ek1   : ek10;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_bin"},  32'(o_bin),  32'd0);
        check({tag, "_cv"},   32'(o_cv),   32'd0);
        check({tag, "_busy"}, 32'(o_busy), 32'd0);
        check({tag, "_done"}, 32'(o_done), 32'd0);
        check({tag, "_err"},  32'(o_err),  32'd0);
        check({tag, "_ek"},   32'(o_ek),   32'd0);
        check({tag, "_ec"},   32'(o_ec),   32'd0);
    endtask

    // Pulse start, then follow the sweep cycle by cycle against the model.
    task automatic do_sweep(input string name, input int step, input int pause_at,
                            input int pause_len, input int restart_at, input int exp_busy,
                            input logic [1:0] exp_kind, input logic [W-1:0] exp_code);
        int  k        = 0;
        int  e        = 0;      // unpaused edges since entry
        int  cv_cnt   = 0;
        int  seq_bad  = 0;
        bit  pend     = 1'b0;   // a sample edge happened at the end of last cycle
        bit  paused;
        int  exp_bin;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (o_busy && k < 1000) begin
            exp_bin = (e / step > 15) ? 15 : e / step;
            if (o_bin !== W'(exp_bin)) seq_bad++;
            if (o_cv !== pend) seq_bad++;
            if (o_cv) cv_cnt++;
            paused = (pause_at >= 0) && (k >= pause_at) && (k < pause_at + pause_len);
            pause  = paused;
            start  = (k == restart_at);
            pend   = !paused && (e % step == step - 1);
            if (!paused) e++;
            @(posedge clk); #1;
            k++;
        end
        pause = 1'b0;
        start = 1'b0;
        if (o_cv) cv_cnt++;
        check({name, "_timeout"}, 32'(k < 1000), 32'd1);
        check({name, "_seq"},     32'(seq_bad),  32'd0);
        check({name, "_busy_cyc"}, 32'(k),       32'(exp_busy));
        check({name, "_last_cv"}, 32'(o_cv),     32'd1);
        check({name, "_cv_cnt"},  32'(cv_cnt),   32'd16);
        check({name, "_done"},    32'(o_done),   32'd1);
        check({name, "_bin"},     32'(o_bin),    32'd15);
        check({name, "_err"},     32'(o_err),    32'(|exp_kind));
        check({name, "_ek"},      32'(o_ek),     32'(exp_kind));
        check({name, "_ec"},      32'(o_ec),     32'(exp_code));
        // DONE holds its status once the code_valid pulse has passed.
        @(posedge clk); #1;
        check({name, "_hold_cv"},   32'(o_cv),   32'd0);
        check({name, "_hold_done"}, 32'(o_done), 32'd1);
        check({name, "_hold_ek"},   32'(o_ek),   32'(exp_kind));
    endtask

    initial begin
        int k;
        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check_idle_zero("rst10");
        sel = 1'b1; #1;
        check_idle_zero("rst1");
        sel = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_no_start", 32'(o_busy), 32'd0);

        // 1: nominal sweep.
        do_sweep("nominal", 10, -1, 0, -1, 160, 2'b00, 4'd0);

        // 2: faulty converter at code 5.
        fault = 1'b1;
        do_sweep("fault", 10, -1, 0, -1, 160, 2'b11, 4'd5);
        fault = 1'b0;

        // Restart from DONE clears the error fields.
        do_sweep("clear", 10, -1, 0, -1, 160, 2'b00, 4'd0);

        // 3: pause for 7 cycles while code 3 is held.
        do_sweep("pause", 10, 35, 7, -1, 167, 2'b00, 4'd0);

        // 4: start during RUN is ignored.
        do_sweep("restart", 10, -1, 0, 50, 160, 2'b00, 4'd0);

        // 5: asynchronous reset mid-sweep at code 7.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (o_bin != 4'd7 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        check("rst_reach7", 32'(o_bin), 32'd7);
        rst_n = 1'b0;
        #1;
        check_idle_zero("rst_mid");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_stay_idle", 32'(o_busy), 32'd0);
        do_sweep("post_rst", 10, -1, 0, -1, 160, 2'b00, 4'd0);

        // 6: STEP_CYCLES=1 instance.
        sel = 1'b1;
        #1;
        do_sweep("step1", 1, -1, 0, -1, 16, 2'b00, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
